// File: rtl/dbus_axi_bridge_if.sv
// Bus bundle for dbus_axi_bridge: CPU dbus request/response side plus AXI4 single-transfer master side.
// The master modport is the bridge's view; the slave modport is the core + AXI slave environment.
interface dbus_axi_bridge_if;
    logic        s_en;
    logic [3:0]  s_we;
    logic [1:0]  s_size;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_uncached;
    logic [31:0] s_rdata;
    logic        s_stall;
    logic        s_error;

    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [2:0]  m_arsize;
    logic [3:0]  m_arcache;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    logic [3:0]  m_awid;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awsize;
    logic [3:0]  m_awcache;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    modport master (
        input  s_en, s_we, s_size, s_addr, s_wdata, s_uncached,
        output s_rdata, s_stall, s_error,
        output m_arid, m_araddr, m_arsize, m_arcache, m_arvalid,
        input  m_arready,
        input  m_rdata, m_rresp, m_rvalid,
        output m_rready,
        output m_awid, m_awaddr, m_awsize, m_awcache, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        output s_en, s_we, s_size, s_addr, s_wdata, s_uncached,
        input  s_rdata, s_stall, s_error,
        input  m_arid, m_araddr, m_arsize, m_arcache, m_arvalid,
        output m_arready,
        output m_rdata, m_rresp, m_rvalid,
        input  m_rready,
        input  m_awid, m_awaddr, m_awsize, m_awcache, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/dbus_axi_bridge.sv
// dbus_axi_bridge: serialises single-beat CPU loads/stores into AXI4 single transfers (ARLEN=0, INCR, WLAST=1).
// Define DBUS_WBUF_EN to add a one-entry posted write buffer drained by a separate write FSM.
//   state | meaning
//   IDLE  | waiting for a request (write FSM: buffer empty)
//   AR    | read address valid
//   R     | waiting for read data
//   AW_W  | write address/data valid, each dropping after its own handshake
//   B     | waiting for write response
//   DONE  | completion cycle, stall released, rdata/error valid
module dbus_axi_bridge #(
    parameter logic [3:0] AXI_ID      = 4'h0,
    parameter logic [3:0] CACHED_ATTR = 4'b1111
) (
    input logic               clk,
    input logic               rst,
    dbus_axi_bridge_if.master bus
);
    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

    state_t      state, state_nxt;
    state_t      wr_st;
    logic [31:0] raddr_q, waddr_q, wdata_q, rdata_q;
    logic [1:0]  rsize_q, wsize_q;
    logic [3:0]  wstrb_q;
    logic        runc_q, wunc_q, err_q;
    logic        aw_ok, w_ok;
    logic        aw_hs, w_hs, wr_both, wr_idle;
    logic        load_go, store_go;

    assign aw_hs    = bus.m_awvalid & bus.m_awready;
    assign w_hs     = bus.m_wvalid & bus.m_wready;
    assign wr_both  = (aw_ok | aw_hs) & (w_ok | w_hs);
    assign wr_idle  = (wr_st == IDLE);
    // With the write buffer busy, both loads and stores wait in IDLE so program order holds.
    assign load_go  = (state == IDLE) & bus.s_en & (bus.s_we == 4'b0000) & wr_idle;
    assign store_go = (state == IDLE) & bus.s_en & (bus.s_we != 4'b0000) & wr_idle;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_go)
                    state_nxt = AR;
`ifdef DBUS_WBUF_EN
                else if (store_go)
                    state_nxt = DONE;
`else
                else if (store_go)
                    state_nxt = AW_W;
`endif
            end
            AR:      if (bus.m_arready) state_nxt = R;
            R:       if (bus.m_rvalid)  state_nxt = DONE;
            AW_W:    if (wr_both)       state_nxt = B;
            B:       if (bus.m_bvalid)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DBUS_WBUF_EN
    state_t wr_nxt;

    always_comb begin
        wr_nxt = wr_st;
        case (wr_st)
            IDLE:    if (store_go)     wr_nxt = AW_W;
            AW_W:    if (wr_both)      wr_nxt = B;
            B:       if (bus.m_bvalid) wr_nxt = IDLE;
            default: wr_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wr_st <= IDLE;
        else      wr_st <= wr_nxt;
    end

    // Posted-write errors are imprecise: flagged at bvalid regardless of what the core is doing.
    assign bus.s_error = ((state == DONE) & err_q) | ((wr_st == B) & bus.m_bvalid & bus.m_bresp[1]);
`else
    assign wr_st       = state;
    assign bus.s_error = (state == DONE) & err_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            raddr_q <= '0;
            rsize_q <= '0;
            runc_q  <= 1'b0;
            waddr_q <= '0;
            wsize_q <= '0;
            wunc_q  <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_ok   <= 1'b0;
            w_ok    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_go) begin
                raddr_q <= bus.s_addr;
                rsize_q <= bus.s_size;
                runc_q  <= bus.s_uncached;
            end
            if (store_go) begin
                waddr_q <= bus.s_addr;
                wsize_q <= bus.s_size;
                wunc_q  <= bus.s_uncached;
                wdata_q <= bus.s_wdata;
                wstrb_q <= bus.s_we;
                err_q   <= 1'b0;
            end
            if ((state == R) && bus.m_rvalid) begin
                rdata_q <= bus.m_rdata;
                err_q   <= bus.m_rresp[1];
            end
            if ((state == B) && bus.m_bvalid)
                err_q <= bus.m_bresp[1];
            if (wr_st == AW_W) begin
                if (wr_both) begin
                    aw_ok <= 1'b0;
                    w_ok  <= 1'b0;
                end else begin
                    aw_ok <= aw_ok | aw_hs;
                    w_ok  <= w_ok | w_hs;
                end
            end
        end
    end

    assign bus.m_arid    = AXI_ID;
    assign bus.m_araddr  = raddr_q;
    assign bus.m_arsize  = {1'b0, rsize_q};
    assign bus.m_arcache = runc_q ? 4'b0000 : CACHED_ATTR;
    assign bus.m_arvalid = (state == AR);
    assign bus.m_rready  = (state == R);

    assign bus.m_awid    = AXI_ID;
    assign bus.m_awaddr  = waddr_q;
    assign bus.m_awsize  = {1'b0, wsize_q};
    assign bus.m_awcache = wunc_q ? 4'b0000 : CACHED_ATTR;
    assign bus.m_awvalid = (wr_st == AW_W) & ~aw_ok;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = wstrb_q;
    assign bus.m_wvalid  = (wr_st == AW_W) & ~w_ok;
    assign bus.m_bready  = (wr_st == B);

    assign bus.s_rdata   = rdata_q;
    assign bus.s_stall   = bus.s_en & (state != DONE);
endmodule
